// File: rtl/p_hardisc.sv
// Shared MDU definitions: function encodings, controller states and the
// decode helpers used by both the datapath and the reuse comparator.
package p_hardisc;

   typedef logic [2:0] f_part;

   localparam f_part MUL    = 3'b000;
   localparam f_part MULH   = 3'b001;
   localparam f_part MULHSU = 3'b010;
   localparam f_part MULHU  = 3'b011;
   localparam f_part DIV    = 3'b100;
   localparam f_part DIVU   = 3'b101;
   localparam f_part REM    = 3'b110;
   localparam f_part REMU   = 3'b111;

   localparam int SEEGR_CORE_WIRE = 1;

   typedef enum logic [2:0] {IDLE, PREP, CALC, CORR, DONE} mdu_state;

   function automatic logic f_is_mul(input f_part f);
      return ~f[2];
   endfunction

   // operand1 treated as signed
   function automatic logic f_sgn1(input f_part f);
      return f[2] ? ~f[0] : (f != MULHU);
   endfunction

   // operand2 treated as signed
   function automatic logic f_sgn2(input f_part f);
      return f[2] ? ~f[0] : ~f[1];
   endfunction

   // result comes from the low half of the accumulator (product low / quotient)
   function automatic logic f_sel_low(input f_part f);
      return (f == MUL) | (f[2:1] == 2'b10);
   endfunction

endpackage

// File: rtl/mdu_step.sv
// One CALC iteration: BPC shift-add (multiply) or compare-subtract
// (restoring divide) stages on the packed {high, low} accumulator.
module mdu_step #(
   parameter int XLEN = 32,
   parameter int BPC  = 1
)(
   input  logic                s_div_i,
   input  logic [2*XLEN-1:0]   s_acc_i,
   input  logic [XLEN-1:0]     s_opr_i,
   output logic [2*XLEN-1:0]   s_acc_o
);

   logic [2*XLEN-1:0] w_acc;
   logic [XLEN:0]     w_sum;
   logic [XLEN:0]     w_shf;

   // chain BPC single-bit stages; multiply shifts right, divide shifts left
   always_comb begin
      w_acc = s_acc_i;
      w_sum = '0;
      w_shf = '0;
      for (int i = 0; i < BPC; i++) begin
         if (s_div_i) begin
            w_shf = {w_acc[2*XLEN-1:XLEN], w_acc[XLEN-1]};
            if (w_shf >= {1'b0, s_opr_i}) begin
               w_sum = w_shf - {1'b0, s_opr_i};
               w_acc = {w_sum[XLEN-1:0], w_acc[XLEN-2:0], 1'b1};
            end else begin
               w_acc = {w_shf[XLEN-1:0], w_acc[XLEN-2:0], 1'b0};
            end
         end else begin
            w_sum = {1'b0, w_acc[2*XLEN-1:XLEN]} + (w_acc[0] ? {1'b0, s_opr_i} : '0);
            w_acc = {w_sum, w_acc[XLEN-1:1]};
         end
      end
   end

   assign s_acc_o = w_acc;

endmodule

// File: rtl/see_wires.sv
// Fault-injection hook point on core wires; every group is a straight
// connection in this build.
module see_wires
   import p_hardisc::*;
#(
   parameter int W     = 1,
   parameter int GROUP = SEEGR_CORE_WIRE
)(
   input  logic [W-1:0] s_d_i,
   output logic [W-1:0] s_d_o
);

   generate
      if (GROUP == SEEGR_CORE_WIRE) begin : g_core
         assign s_d_o = s_d_i;
      end else begin : g_other
         assign s_d_o = s_d_i;
      end
   endgenerate

endmodule

// File: rtl/mdu_radix.sv
// Iterative multiply/divide unit retiring BPC result bits per cycle, with
// optional reuse of the previous full result (product or quotient+remainder).
//
// state | meaning
// IDLE  | waiting for a request; reuse hit jumps straight to DONE
// PREP  | latch operands, take magnitudes, record signs; catch special divides
// CALC  | N = XLEN/BPC iterations of mdu_step
// CORR  | sign fix and half select into the result register
// DONE  | result valid; held while stalled
module mdu_radix
   import p_hardisc::*;
#(
   parameter int XLEN  = 32,
   parameter int BPC   = 1,
   parameter int REUSE = 1
)(
   input  logic            s_clk_i,
   input  logic            s_reset_i,
   input  logic            s_stall_i,
   input  logic            s_flush_i,
   input  logic            s_compute_i,
   input  f_part           s_function_i,
   input  logic [XLEN-1:0] s_operand1_i,
   input  logic [XLEN-1:0] s_operand2_i,
   output logic            s_finished_o,
   output logic            s_busy_o,
   output logic [XLEN-1:0] s_result_o
);

   localparam int N  = XLEN / BPC;
   localparam int CW = $clog2(N + 1);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state          r_state, w_next;
   logic [CW-1:0]     r_cnt;
   logic [2*XLEN-1:0] r_acc, w_step, w_fix;
   logic [XLEN-1:0]   r_b, r_op1, r_op2, r_result;
   logic [XLEN-1:0]   w_abs1, w_abs2, w_quot, w_rem, w_spec;
   f_part             r_func;
   logic              r_neg_q, r_neg_r, r_reuse_v, r_finished;
   logic              w_is_mul, w_neg1, w_neg2, w_dz, w_ovf, w_special, w_hit, w_div;

   assign w_is_mul  = f_is_mul(s_function_i);
   assign w_neg1    = f_sgn1(s_function_i) & s_operand1_i[XLEN-1];
   assign w_neg2    = f_sgn2(s_function_i) & s_operand2_i[XLEN-1];
   assign w_abs1    = w_neg1 ? -s_operand1_i : s_operand1_i;
   assign w_abs2    = w_neg2 ? -s_operand2_i : s_operand2_i;
   assign w_dz      = ~w_is_mul & (s_operand2_i == '0);
   assign w_ovf     = ~w_is_mul & ~s_function_i[0] & (s_operand1_i == MOST_NEG) & (&s_operand2_i);
   assign w_special = w_dz | w_ovf;
   assign w_spec    = f_sel_low(s_function_i) ? (w_dz ? {XLEN{1'b1}} : MOST_NEG)
                                              : (w_dz ? s_operand1_i : '0);

   // the stored accumulator holds the whole sign-corrected result, so any op
   // of the same class and sign mode can pick its half without recomputing
   assign w_hit = (REUSE != 0) & r_reuse_v
                & (s_operand1_i == r_op1) & (s_operand2_i == r_op2)
                & (w_is_mul == f_is_mul(r_func))
                & (f_sgn1(s_function_i) == f_sgn1(r_func))
                & (f_sgn2(s_function_i) == f_sgn2(r_func));

   assign w_div  = ~f_is_mul(r_func);
   assign w_quot = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
   assign w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
   assign w_fix  = w_div ? {w_rem, w_quot} : (r_neg_q ? -r_acc : r_acc);

   mdu_step #(.XLEN(XLEN), .BPC(BPC)) u_step (
      .s_div_i (w_div),
      .s_acc_i (r_acc),
      .s_opr_i (r_b),
      .s_acc_o (w_step)
   );

   // state register
   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) r_state <= IDLE;
      else           r_state <= w_next;
   end

   // next-state; flush overrides every other transition
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (s_compute_i) w_next = w_hit ? DONE : PREP;
         PREP:    w_next = w_special ? DONE : CALC;
         CALC:    if (r_cnt == CW'(1)) w_next = CORR;
         CORR:    w_next = DONE;
         DONE:    if (!s_stall_i) w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (s_flush_i) w_next = IDLE;
   end

   // control registers: iteration down-counter, reuse validity, result, finished
   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         r_cnt      <= '0;
         r_reuse_v  <= 1'b0;
         r_finished <= 1'b0;
         r_result   <= '0;
      end else begin
         r_finished <= (w_next == DONE);
         if (r_state == PREP)      r_cnt <= CW'(N);
         else if (r_state == CALC) r_cnt <= r_cnt - CW'(1);
         if (s_flush_i)                                        r_reuse_v <= 1'b0;
         else if (r_state == IDLE && s_compute_i && !w_hit)    r_reuse_v <= 1'b0;
         else if (r_state == CORR)                             r_reuse_v <= 1'b1;
         if (r_state == IDLE && s_compute_i && w_hit)
            r_result <= f_sel_low(s_function_i) ? r_acc[XLEN-1:0] : r_acc[2*XLEN-1:XLEN];
         else if (r_state == PREP && w_special)
            r_result <= w_spec;
         else if (r_state == CORR)
            r_result <= f_sel_low(r_func) ? w_fix[XLEN-1:0] : w_fix[2*XLEN-1:XLEN];
      end
   end

   // datapath registers; multiplier goes in the low half, dividend likewise
   always_ff @(posedge s_clk_i) begin
      case (r_state)
         PREP: begin
            r_op1   <= s_operand1_i;
            r_op2   <= s_operand2_i;
            r_func  <= s_function_i;
            r_neg_q <= w_neg1 ^ w_neg2;
            r_neg_r <= w_neg1;
            r_b     <= w_is_mul ? w_abs1 : w_abs2;
            r_acc   <= {{XLEN{1'b0}}, (w_is_mul ? w_abs2 : w_abs1)};
         end
         CALC:    r_acc <= w_step;
         CORR:    r_acc <= w_fix;
         default: ;
      endcase
   end

   assign s_busy_o = (r_state != IDLE);

   see_wires #(.W(XLEN), .GROUP(SEEGR_CORE_WIRE)) u_see_result (
      .s_d_i (r_result),
      .s_d_o (s_result_o)
   );

   see_wires #(.W(1), .GROUP(SEEGR_CORE_WIRE)) u_see_finished (
      .s_d_i (r_finished),
      .s_d_o (s_finished_o)
   );

endmodule

// File: tb/tb_mdu_radix.sv
// Directed bench for mdu_radix: default build, a no-reuse build and a
// radix-16 (BPC=4) build sharing one set of stimulus wires.
module tb_mdu_radix;
   import p_hardisc::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  comp = 3'b000;
   f_part       func = MUL;
   logic [31:0] op1 = '0;
   logic [31:0] op2 = '0;

   logic        fin0, fin1, fin2, busy0, busy1, busy2;
   logic [31:0] res0, res1, res2, res_m;
   logic [2:0]  fin_v, busy_v;
   int          sel = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] ra, rb;
   f_part       rf;

   always #5 clk = ~clk;

   assign fin_v  = {fin2, fin1, fin0};
   assign busy_v = {busy2, busy1, busy0};
   assign res_m  = (sel == 0) ? res0 : (sel == 1) ? res1 : res2;

   mdu_radix #(.XLEN(32), .BPC(1), .REUSE(1)) u_dut (
      .s_clk_i(clk), .s_reset_i(rst), .s_stall_i(stall), .s_flush_i(flush),
      .s_compute_i(comp[0]), .s_function_i(func), .s_operand1_i(op1), .s_operand2_i(op2),
      .s_finished_o(fin0), .s_busy_o(busy0), .s_result_o(res0));

   mdu_radix #(.XLEN(32), .BPC(1), .REUSE(0)) u_nr (
      .s_clk_i(clk), .s_reset_i(rst), .s_stall_i(stall), .s_flush_i(flush),
      .s_compute_i(comp[1]), .s_function_i(func), .s_operand1_i(op1), .s_operand2_i(op2),
      .s_finished_o(fin1), .s_busy_o(busy1), .s_result_o(res1));

   mdu_radix #(.XLEN(32), .BPC(4), .REUSE(1)) u_b4 (
      .s_clk_i(clk), .s_reset_i(rst), .s_stall_i(stall), .s_flush_i(flush),
      .s_compute_i(comp[2]), .s_function_i(func), .s_operand1_i(op1), .s_operand2_i(op2),
      .s_finished_o(fin2), .s_busy_o(busy2), .s_result_o(res2));

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_mdu(input f_part fn, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ua, ub, q;
      logic [63:0] p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      p  = '0;
      q  = '0;
      case (fn)
         MUL:    begin p = sa * sb; return p[31:0];  end
         MULH:   begin p = sa * sb; return p[63:32]; end
         MULHSU: begin p = sa * ub; return p[63:32]; end
         MULHU:  begin p = ua * ub; return p[63:32]; end
         DIV:    begin if (b == 0) return 32'hFFFFFFFF; q = sa / sb; return q[31:0]; end
         DIVU:   begin if (b == 0) return 32'hFFFFFFFF; q = ua / ub; return q[31:0]; end
         REM:    begin if (b == 0) return a; q = sa % sb; return q[31:0]; end
         default: begin if (b == 0) return a; q = ua % ub; return q[31:0]; end
      endcase
   endfunction

   // issue one request from posedge+1, measure latency, optionally stall, consume
   task automatic run_op(input int s, input f_part fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_cyc, input int nstall, input string tag);
      int cyc;
      cyc  = 0;
      sel  = s;
      func = fn;
      op1  = a;
      op2  = b;
      comp[s] = 1'b1;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!fin_v[s] && cyc < 200);
      check_eq({tag, " latency"}, 64'(cyc), 64'(exp_cyc));
      check_eq({tag, " result"}, {32'b0, res_m}, {32'b0, exp_res});
      if (nstall > 0) begin
         stall = 1'b1;
         for (int j = 0; j < nstall; j++) begin
            @(posedge clk); #1;
            check_eq({tag, " stall fin"}, {63'b0, fin_v[s]}, 64'd1);
            check_eq({tag, " stall res"}, {32'b0, res_m}, {32'b0, exp_res});
         end
         stall = 1'b0;
      end
      @(posedge clk); #1;
      comp[s] = 1'b0;
      check_eq({tag, " consumed"}, {63'b0, fin_v[s]}, 64'd0);
   endtask

   // a request must stay up while its unit is busy unless flushed or reset
   always @(negedge clk) begin
      if (!rst && !flush) begin
         for (int k = 0; k < 3; k++)
            if (busy_v[k] && !comp[k]) check_eq("compute_held", {63'b0, comp[k]}, 64'd1);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset busy", {63'b0, busy0}, 64'd0);
      check_eq("reset fin",  {63'b0, fin0},  64'd0);
      check_eq("reset res",  {32'b0, res0},  64'd0);
      rst = 1'b0;

      run_op(0, MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 35, 0, "mul");
      run_op(0, MULH,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 1,  0, "mulh reuse");
      run_op(0, MULHU,  32'd7,        32'hFFFFFFFD, 32'h00000006, 35, 0, "mulhu no reuse");
      run_op(0, MULHSU, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 35, 0, "mulhsu");
      run_op(0, DIVU,   32'd100,      32'd7,        32'd14,       35, 0, "divu");
      run_op(0, REMU,   32'd100,      32'd7,        32'd2,        1,  0, "remu reuse");
      run_op(0, DIV,    32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 35, 0, "div neg");
      run_op(0, REM,    32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 1,  0, "rem neg reuse");
      run_op(0, DIVU,   32'hFFFFFF9C, 32'd7,        32'h24924916, 35, 0, "divu big");
      run_op(0, REMU,   32'hFFFFFF9C, 32'd7,        32'd2,        1,  0, "remu big reuse");
      run_op(0, DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 2,  0, "div by zero");
      run_op(0, REM,    32'd5,        32'd0,        32'd5,        2,  0, "rem by zero");
      run_op(0, DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2,  0, "div ovf");
      run_op(0, REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        2,  0, "rem ovf");
      run_op(0, DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 2,  0, "divu by zero");
      run_op(0, REMU,   32'd5,        32'd0,        32'd5,        2,  0, "remu by zero");

      // flush during CALC
      sel = 0; func = MULHU; op1 = 32'hFFFFFFFF; op2 = 32'hFFFFFFFF; comp[0] = 1'b1;
      repeat (10) begin @(posedge clk); #1; end
      flush = 1'b1; comp[0] = 1'b0;
      @(posedge clk); #1;
      check_eq("flush busy", {63'b0, busy0}, 64'd0);
      check_eq("flush fin",  {63'b0, fin0},  64'd0);
      flush = 1'b0;
      run_op(0, MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35, 0, "mulhu reissue");
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      run_op(0, MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35, 0, "mulhu after flush");

      // reset in the middle of a divide
      sel = 0; func = DIV; op1 = 32'd1000; op2 = 32'hFFFFFFFD; comp[0] = 1'b1;
      repeat (20) begin @(posedge clk); #1; end
      rst = 1'b1; comp[0] = 1'b0;
      @(posedge clk); #1;
      check_eq("midreset busy", {63'b0, busy0}, 64'd0);
      check_eq("midreset fin",  {63'b0, fin0},  64'd0);
      check_eq("midreset res",  {32'b0, res0},  64'd0);
      rst = 1'b0;
      run_op(0, DIV, 32'd1000, 32'hFFFFFFFD, 32'hFFFFFEB3, 35, 3, "div stall");

      run_op(1, DIVU, 32'd100, 32'd7, 32'd14, 35, 0, "nr divu");
      run_op(1, REMU, 32'd100, 32'd7, 32'd2,  35, 0, "nr remu");

      run_op(2, MUL,  32'd7,   32'hFFFFFFFD, 32'hFFFFFFEB, 11, 0, "b4 mul");
      run_op(2, DIVU, 32'd100, 32'd7,        32'd14,       11, 0, "b4 divu");
      for (int i = 0; i < 16; i++) begin
         rf = f_part'(i % 8);
         ra = $urandom;
         rb = $urandom;
         if (i % 4 == 1) rb = rb >> 20;
         if (rb == 32'd0) rb = 32'd1;
         if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
         run_op(2, rf, ra, rb, ref_mdu(rf, ra, rb), 11, 0, "b4 rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mdu_radix.md
MDU_RADIX -- requirements
Module: mdu_radix

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter BPC, default 1, result bits retired per CALC cycle; legal values 1, 2, 4, 8; XLEN mod BPC = 0.
REQ-003 SHALL have parameter REUSE, default 1: 1 enables result reuse (REQ-019), 0 removes it.
REQ-004 s_clk_i  in  1  clock, all state on rising edge.
REQ-005 s_reset_i  in  1  reset; one clock; reset is synchronous and active-high.
REQ-006 s_stall_i  in  1  downstream stall; holds a finished result.
REQ-007 s_flush_i  in  1  aborts any operation in flight.
REQ-008 s_compute_i  in  1  request; held high with stable operands and function until consumed.
REQ-009 s_function_i  in  f_part  MDU function: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-010 s_operand1_i, s_operand2_i  in  XLEN  operands (dividend/multiplicand first).
REQ-011 s_finished_o  out  1  result valid, registered.
REQ-012 s_busy_o  out  1  state is not IDLE.
REQ-013 s_result_o  out  XLEN  result, registered, valid while s_finished_o=1.

Function
REQ-014 FSM states: IDLE, PREP, CALC, CORR, DONE.
- IDLE->PREP: s_compute_i=1, s_flush_i=0, no reuse hit.
- PREP->CALC normally.
- PREP->DONE for divide-by-zero or signed overflow.
- CALC->CORR after N=XLEN/BPC iterations.
- CORR->DONE.
- DONE->IDLE when s_stall_i=0.
REQ-015 PREP SHALL latch operands, take absolute values per signedness, and record result sign.
REQ-016 CALC SHALL use a shift-add multiplier into a 2*XLEN product, or a restoring divider yielding quotient and remainder, at BPC bits per cycle, counted by a ceil(log2(N+1))-bit counter.
REQ-017 CORR SHALL apply the sign fix and select:
- low XLEN bits for MUL;
- high XLEN bits for MULH/MULHSU/MULHU;
- quotient for DIV/DIVU;
- remainder for REM/REMU.
REQ-018 Latency, counted from the accept cycle as cycle 0:
- s_finished_o=1 from cycle N+3.
- Special divide cases finish from cycle 2.
REQ-019 Reuse hit (REUSE=1) occurs in IDLE when the stored operands equal the new ones and either:
- the stored op was in MUL/MULH/MULHSU/MULHU with identical sign mode per operand; or
- the stored op was DIV/REM (or DIVU/REMU) of the same signedness.
On a hit the FSM SHALL go IDLE->DONE, with s_finished_o=1 at cycle 1.
REQ-020 Divide by zero: quotient all ones, remainder = operand1. Signed overflow (most-negative / -1): quotient = most-negative, remainder = 0.
REQ-021 A result is consumed in the cycle with s_finished_o=1 and s_stall_i=0. s_finished_o SHALL be 0 the next cycle. A new request is accepted from IDLE the following cycle.
REQ-022 While in DONE with s_stall_i=1, s_result_o and s_finished_o SHALL hold constant.
REQ-023 s_flush_i=1 in any state SHALL force IDLE next cycle, clear s_finished_o, and invalidate reuse state. Flush has priority over consume and accept in the same cycle.
REQ-024 Deassertion of s_compute_i before consumption is illegal and need not be handled; the bench SHALL flag it.

Reset
REQ-025 On s_reset_i=1 at a clock edge the block SHALL enter IDLE and clear counter, reuse-valid, s_finished_o=0, s_busy_o=0, s_result_o=0. This applies mid-operation.
REQ-026 Datapath registers other than s_result_o need no reset.

Structure
REQ-027 MDU function encodings (f_part constants) and the state enum SHALL live in p_hardisc. No new local typedefs.
REQ-028 One sub-module, mdu_step: combinational single iteration (BPC add/shift or compare/subtract stages), instantiated once.
REQ-029 Result and finished outputs SHALL pass through see_wires (group SEEGR_CORE_WIRE) in the same manner as the executor.

Verification (XLEN=32, BPC=1 unless noted)
REQ-030 MUL 7 x 0xFFFFFFFD -> s_result_o=0xFFFFFFEB, s_finished_o first high at cycle 35; MULH same operands at cycle 36 -> 0xFFFFFFFF, finished at cycle 1 (reuse hit).
REQ-031 DIVU 100/7 -> 14 at cycle 35; then REMU 100/7 -> 2 at cycle 1. With REUSE=0 the REMU result is at cycle 35.
REQ-032 DIV 5/0 -> 0xFFFFFFFF at cycle 2; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM of the same operands -> 0, each at cycle 2.
REQ-033 Flush at cycle 10 of MULHU 0xFFFFFFFF x 0xFFFFFFFF -> s_busy_o=0 at cycle 11, no finished. A re-issued request gives 0xFFFFFFFE at N+3, with no reuse hit.
REQ-034 Stall high for 3 cycles at finish -> result and finished stable for 3 cycles, consumed on cycle 4. Reset at cycle 20 of a DIV -> all outputs 0 the next cycle.
REQ-035 BPC=4: random signed/unsigned pairs vs reference model; every result at cycle 11.
